// File: rtl/tape_pkg.sv
// Shared definitions for the cassette ADC slicer: default widths,
// slicer FSM states and the sample type.
package tape_pkg;

   localparam int TAPE_SAMPLE_W = 12;
   localparam int TAPE_AVG_LOG2 = 9;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      UPDATE,
      SLICE
   } slicer_state_t;

   typedef logic [TAPE_SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/tape_avg_ram.sv
// Simple dual-port sample history RAM with a registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module tape_avg_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/tape_adc_slicer.sv
// Cassette ADC front-end: running mean over a sample window, hysteresis
// slicer producing the cassette bit, and transition period measurement.
module tape_adc_slicer
   import tape_pkg::*;
#(
   parameter int SAMPLE_W = TAPE_SAMPLE_W,
   parameter int AVG_LOG2 = TAPE_AVG_LOG2,
   parameter int HYST     = 100,
   parameter int PERIOD_W = 20
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_sync,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic [SAMPLE_W-1:0] avg_out,
   output logic                avg_valid,
   output logic                cas_bit,
   output logic                cas_edge,
   output logic [PERIOD_W-1:0] period,
   output logic                overrun
);

   localparam int SUM_W  = SAMPLE_W + AVG_LOG2;
   localparam int CMP_W  = SAMPLE_W + 2;
   localparam int FILL_W = AVG_LOG2 + 1;

   slicer_state_t       state_reg, state_next;
   logic                sync_reg;
   logic                pend_reg;
   logic [SAMPLE_W-1:0] pend_data_reg;
   logic [SAMPLE_W-1:0] cur_reg;
   logic [AVG_LOG2-1:0] wptr_reg;
   logic [FILL_W-1:0]   fill_reg;
   logic [SUM_W-1:0]    sum_reg, sum_next;
   logic [PERIOD_W-1:0] cnt_reg;

   logic                arrival, ram_re, ram_we, fill_full, bit_next;
   logic [SAMPLE_W-1:0] ram_rdata, old_eff, avg_next;
   logic [CMP_W-1:0]    cur_ext, avg_ext;

   assign arrival   = adc_sync ^ sync_reg;
   assign ram_re    = (state_reg == IDLE) && pend_reg;
   assign ram_we    = (state_reg == UPDATE);
   // fill saturates at exactly 2^AVG_LOG2, so its top bit means "window full"
   assign fill_full = fill_reg[AVG_LOG2];
   assign old_eff   = fill_full ? ram_rdata : '0;
   assign sum_next  = sum_reg + SUM_W'(cur_reg) - SUM_W'(old_eff);
   assign avg_next  = sum_reg[SUM_W-1 -: SAMPLE_W];
   assign cur_ext   = CMP_W'(cur_reg);
   assign avg_ext   = CMP_W'(avg_next);

   tape_avg_ram #(
      .ADDR_W(AVG_LOG2),
      .DATA_W(SAMPLE_W)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(wptr_reg),
      .wdata(cur_reg),
      .re   (ram_re),
      .raddr(wptr_reg),
      .rdata(ram_rdata)
   );

   always_comb begin
      bit_next = cas_bit;
      if (avg_valid) begin
         if (cur_ext + CMP_W'(HYST) < avg_ext)
            bit_next = 1'b1;
         else if (cur_ext > avg_ext + CMP_W'(HYST))
            bit_next = 1'b0;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (pend_reg) state_next = READ;
         READ:    state_next = UPDATE;
         UPDATE:  state_next = SLICE;
         SLICE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A new arrival always replaces pending; it is only a loss when the
   // FSM cannot consume the older one in this same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_reg      <= 1'b0;
         pend_reg      <= 1'b0;
         pend_data_reg <= '0;
         overrun       <= 1'b0;
      end else begin
         sync_reg <= adc_sync;
         if (arrival) begin
            pend_data_reg <= adc_data;
            pend_reg      <= 1'b1;
            if (pend_reg && state_reg != IDLE)
               overrun <= 1'b1;
         end else if (ram_re) begin
            pend_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         cur_reg    <= '0;
         sample_out <= '0;
         sum_reg    <= '0;
         wptr_reg   <= '0;
         fill_reg   <= '0;
         avg_valid  <= 1'b0;
         avg_out    <= '0;
         cas_bit    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (ram_re) begin
            cur_reg    <= pend_data_reg;
            sample_out <= pend_data_reg;
         end
         if (state_reg == UPDATE) begin
            sum_reg  <= sum_next;
            wptr_reg <= wptr_reg + 1'b1;
            if (!fill_full)
               fill_reg <= fill_reg + 1'b1;
            if (fill_reg == FILL_W'((1 << AVG_LOG2) - 1))
               avg_valid <= 1'b1;
         end
         if (state_reg == SLICE) begin
            avg_out <= avg_next;
            cas_bit <= bit_next;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg  <= '0;
         period   <= '0;
         cas_edge <= 1'b0;
      end else begin
         cas_edge <= 1'b0;
         if (state_reg == SLICE && bit_next != cas_bit) begin
            cas_edge <= 1'b1;
            period   <= cnt_reg;
            cnt_reg  <= PERIOD_W'(1);
         end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

endmodule
